i2c_sensor_seq: RTL and testbench

Transaction sequencer in front of the I2C master for the pointer-register sensor (temperature 16b, config 8b, general 8b, default 16b at pointers 0..3). It runs periodic temperature polls and serves single host register requests. Host requests take priority over polls. Each access is expanded into the master's init/rd_wr/wr/addr/cmd/data handshake: a write is one transaction; a read is a pointer-write, bus-free gap, then read.

---
 rtl/i2c_sensor_seq.sv | 187 ++++++++++++++++++
 tb/tb_i2c_sensor_seq.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_sensor_seq.sv
// Transaction sequencer in front of an I2C master for a pointer-register temperature sensor.
// Optional build macro TEMP_ALERT_EN adds alert_hi/alert_lo inputs and a hysteretic alert output.
module i2c_sensor_seq #(
    parameter logic [6:0] SLAVE_ADDR  = 7'h48,
    parameter int         POLL_DIV    = 100000,
    parameter int         GAP_CYC     = 64,
    parameter int         TIMEOUT_CYC = 200000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
    input  logic        host_req,
    input  logic        host_wr,
    input  logic [1:0]  host_ptr,
    input  logic [7:0]  host_wdata,
    output logic        host_ack,
    output logic [15:0] host_rdata,
    output logic        host_err,
    output logic [15:0] temp_q,
    output logic        temp_valid,
    output logic        busy,
    output logic        m_init,
    output logic        m_rd_wr,
    output logic        m_wr,
    output logic [6:0]  m_addr,
    output logic [7:0]  m_cmd,
    output logic [7:0]  m_data,
    input  logic        m_done,
    input  logic [15:0] m_rxdata
`ifdef TEMP_ALERT_EN
    ,
    input  logic [15:0] alert_hi,
    input  logic [15:0] alert_lo,
    output logic        alert
`endif
);

    localparam int PW = $clog2(POLL_DIV);
    localparam int GW = $clog2(GAP_CYC + 1);
    localparam int TW = $clog2(TIMEOUT_CYC + 1);

    typedef enum logic [3:0] {
        IDLE, WR_ISSUE, WR_WAIT, PTR_ISSUE, PTR_WAIT, GAP, RD_ISSUE, RD_WAIT, FINISH
    } state_t;

    state_t         state, state_d;
    logic [PW-1:0]  poll_cnt;
    logic           poll_pend;
    logic [1:0]     lat_ptr;
    logic [7:0]     lat_wdata;
    logic           is_poll;
    logic           err_r;
    logic [15:0]    rdata_r;
    logic [GW-1:0]  gap_cnt;
    logic [TW-1:0]  to_cnt;
    logic           accept, launch, waiting, to_hit, gap_done, poll_capture;

    assign waiting      = (state == WR_WAIT) || (state == PTR_WAIT) || (state == RD_WAIT);
    assign to_hit       = waiting && !m_done && (to_cnt == TW'(TIMEOUT_CYC - 1));
    assign gap_done     = (gap_cnt == GW'(GAP_CYC - 1));
    assign poll_capture = (state == RD_WAIT) && m_done && is_poll;

    // Host handshake: host_req is a level sampled only while IDLE; the access is taken on
    // that edge and answered by exactly one host_ack pulse, and the requester must drop
    // host_req by the ack cycle. Nothing on the host side stalls once a request is taken.
    always_comb begin
        state_d = state;
        accept  = 1'b0;
        launch  = 1'b0;
        case (state)
            IDLE: begin
                if (host_req) begin
                    accept = 1'b1;
                    if (!host_wr)
                        state_d = PTR_ISSUE;
                    else if (host_ptr == 2'd1 || host_ptr == 2'd2)
                        state_d = WR_ISSUE;
                    else
                        state_d = FINISH;
                end else if (poll_pend) begin
                    launch  = 1'b1;
                    state_d = PTR_ISSUE;
                end
            end
            WR_ISSUE:  state_d = WR_WAIT;
            WR_WAIT:   if (m_done || to_hit) state_d = FINISH;
            PTR_ISSUE: state_d = PTR_WAIT;
            PTR_WAIT: begin
                if (m_done)      state_d = GAP;
                else if (to_hit) state_d = FINISH;
            end
            GAP:       if (gap_done) state_d = RD_ISSUE;
            RD_ISSUE:  state_d = RD_WAIT;
            RD_WAIT:   if (m_done || to_hit) state_d = FINISH;
            FINISH:    state_d = IDLE;
            default:   state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            poll_cnt   <= '0;
            poll_pend  <= 1'b0;
            lat_ptr    <= 2'd0;
            lat_wdata  <= 8'h00;
            is_poll    <= 1'b0;
            err_r      <= 1'b0;
            rdata_r    <= 16'h0000;
            gap_cnt    <= '0;
            to_cnt     <= '0;
            temp_q     <= 16'h0000;
            temp_valid <= 1'b0;
        end else begin
            // A wrap coinciding with a launch means a fresh period elapsed, so pend stays set.
            if (!en) begin
                poll_pend <= 1'b0;
            end else if (poll_cnt == PW'(POLL_DIV - 1)) begin
                poll_cnt  <= '0;
                poll_pend <= 1'b1;
            end else begin
                poll_cnt <= poll_cnt + 1'b1;
                if (launch) poll_pend <= 1'b0;
            end

            if (accept) begin
                lat_ptr   <= host_ptr;
                lat_wdata <= host_wdata;
                is_poll   <= 1'b0;
                err_r     <= host_wr && (host_ptr == 2'd0 || host_ptr == 2'd3);
                rdata_r   <= 16'h0000;
            end else if (launch) begin
                lat_ptr   <= 2'd0;
                lat_wdata <= 8'h00;
                is_poll   <= 1'b1;
                err_r     <= 1'b0;
                rdata_r   <= 16'h0000;
            end else if (to_hit) begin
                err_r <= 1'b1;
            end

            if (m_init)       to_cnt <= '0;
            else if (waiting) to_cnt <= to_cnt + 1'b1;

            if (state == GAP) gap_cnt <= gap_cnt + 1'b1;
            else              gap_cnt <= '0;

            if (poll_capture) begin
                temp_q     <= m_rxdata;
                temp_valid <= 1'b1;
            end else if (state == RD_WAIT && m_done) begin
                // 8-bit registers come back left-justified; the low byte is not meaningful.
                if (lat_ptr == 2'd1 || lat_ptr == 2'd2)
                    rdata_r <= {m_rxdata[15:8], 8'h00};
                else
                    rdata_r <= m_rxdata;
            end
        end
    end

`ifdef TEMP_ALERT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            alert <= 1'b0;
        else if (poll_capture) begin
            if ($signed(m_rxdata) > $signed(alert_hi))      alert <= 1'b1;
            else if ($signed(m_rxdata) < $signed(alert_lo)) alert <= 1'b0;
        end
    end
`endif

    assign busy       = (state != IDLE);
    assign m_init     = (state == WR_ISSUE) || (state == PTR_ISSUE) || (state == RD_ISSUE);
    assign m_rd_wr    = (state == RD_ISSUE) || (state == RD_WAIT);
    assign m_wr       = (state == WR_ISSUE) || (state == WR_WAIT);
    assign m_addr     = busy ? SLAVE_ADDR : 7'h00;
    assign m_cmd      = busy ? {6'b0, lat_ptr} : 8'h00;
    assign m_data     = m_wr ? lat_wdata : 8'h00;
    assign host_ack   = (state == FINISH) && !is_poll;
    assign host_rdata = host_ack ? rdata_r : 16'h0000;
    assign host_err   = host_ack && err_r;

endmodule

// File: tb/tb_i2c_sensor_seq.sv
// Bench for i2c_sensor_seq: behavioural sensor/master model, transaction scoreboard,
// table of host accesses plus directed poll, timeout, reset and arbitration sequences.
module tb_i2c_sensor_seq;

    localparam logic [6:0] SLAVE       = 7'h48;
    localparam int         POLL_DIV    = 16;
    localparam int         GAP_CYC     = 10;
    localparam int         TIMEOUT_CYC = 100;
    localparam int         MDL_LAT     = 4;
    localparam int         BUDGET      = 400;

    logic        clk, rst_n, en;
    logic        host_req, host_wr;
    logic [1:0]  host_ptr;
    logic [7:0]  host_wdata;
    logic        host_ack, host_err, temp_valid, busy;
    logic [15:0] host_rdata, temp_q;
    logic        m_init, m_rd_wr, m_wr, m_done;
    logic [6:0]  m_addr;
    logic [7:0]  m_cmd, m_data;
    logic [15:0] m_rxdata;
`ifdef TEMP_ALERT_EN
    logic [15:0] alert_hi, alert_lo;
    logic        alert;
`endif

    i2c_sensor_seq #(
        .SLAVE_ADDR(SLAVE), .POLL_DIV(POLL_DIV), .GAP_CYC(GAP_CYC), .TIMEOUT_CYC(TIMEOUT_CYC)
    ) dut (
        .clk(clk), .rst_n(rst_n), .en(en),
        .host_req(host_req), .host_wr(host_wr), .host_ptr(host_ptr), .host_wdata(host_wdata),
        .host_ack(host_ack), .host_rdata(host_rdata), .host_err(host_err),
        .temp_q(temp_q), .temp_valid(temp_valid), .busy(busy),
        .m_init(m_init), .m_rd_wr(m_rd_wr), .m_wr(m_wr), .m_addr(m_addr),
        .m_cmd(m_cmd), .m_data(m_data), .m_done(m_done), .m_rxdata(m_rxdata)
`ifdef TEMP_ALERT_EN
        , .alert_hi(alert_hi), .alert_lo(alert_lo), .alert(alert)
`endif
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- checking ----------------
    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    endtask

    logic [24:0] exp_q[$];

    function automatic logic [24:0] mk_txn(input logic rd, input logic wr,
                                           input logic [1:0] ptr, input logic [7:0] d);
        return {SLAVE, rd, wr, 6'b0, ptr, d};
    endfunction

    // ---------------- sensor + master model ----------------
    logic [7:0]  reg8 [4];
    logic [15:0] temp_model, def_model;
    logic [1:0]  cur_ptr;
    logic        mute_all, mute_rd;
    int          rd_init_cnt = 0, rd_done_cnt = 0, last_ptr_done_cyc = 0, init_cyc = 0;

    initial begin
        logic [24:0] obs, exp_t;
        logic [17:0] held;
        logic [15:0] resp;
        logic        is_rd, is_ptr;
        m_done   = 1'b0;
        m_rxdata = 16'h0;
        forever begin
            @(negedge clk);
            if (m_init === 1'b1) begin
                obs = {m_addr, m_rd_wr, m_wr, m_cmd, (m_wr ? m_data : 8'h00)};
                if (exp_q.size() == 0) check("sb_unexpected_txn", 64'(obs), 64'(0));
                else begin
                    exp_t = exp_q.pop_front();
                    check("sb_txn", 64'(obs), 64'(exp_t));
                end
                init_cyc = cyc;
                held     = {m_rd_wr, m_wr, m_cmd, m_data};
                is_rd    = m_rd_wr;
                is_ptr   = !m_rd_wr && !m_wr;
                resp     = 16'h0;
                if (m_rd_wr) begin
                    rd_init_cnt++;
                    check("gap_len", 64'(cyc - last_ptr_done_cyc - 1), 64'(GAP_CYC));
                    case (cur_ptr)
                        2'd0:    resp = temp_model;
                        2'd3:    resp = def_model;
                        default: resp = {reg8[cur_ptr], 8'h5A};
                    endcase
                end else begin
                    cur_ptr = m_cmd[1:0];
                    if (m_wr) reg8[m_cmd[1:0]] = m_data;
                end
                if (!(mute_all || (mute_rd && is_rd))) begin
                    repeat (MDL_LAT) @(negedge clk);
                    check("hold_cmd_data", 64'({m_rd_wr, m_wr, m_cmd, m_data}), 64'(held));
                    m_rxdata = resp;
                    m_done   = 1'b1;
                    if (is_ptr) last_ptr_done_cyc = cyc;
                    if (is_rd)  rd_done_cnt++;
                    @(negedge clk);
                    m_done   = 1'b0;
                    m_rxdata = 16'h0;
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic host_op(input logic wr, input logic [1:0] ptr, input logic [7:0] wd,
                           output logic got, output logic [15:0] rd, output logic err,
                           output int ack_cyc);
        int n = 0;
        while (busy && n < BUDGET) begin @(negedge clk); n++; end
        host_wr = wr; host_ptr = ptr; host_wdata = wd; host_req = 1'b1;
        @(negedge clk);
        host_req   = 1'b0;
        host_wr    = 1'($urandom_range(0, 1));
        host_ptr   = 2'($urandom_range(0, 3));
        host_wdata = 8'($urandom_range(0, 255));
        n = 0;
        while (!host_ack && n < BUDGET) begin @(negedge clk); n++; end
        got = host_ack; rd = host_rdata; err = host_err; ack_cyc = cyc;
    endtask

    task automatic do_poll(input logic [15:0] val);
        int n = 0;
        int n0;
        temp_model = val;
        exp_q.push_back(mk_txn(1'b0, 1'b0, 2'd0, 8'h00));
        exp_q.push_back(mk_txn(1'b1, 1'b0, 2'd0, 8'h00));
        n0 = rd_done_cnt;
        en = 1'b1;
        while (rd_done_cnt == n0 && n < BUDGET) begin @(negedge clk); n++; end
        en = 1'b0;
        check("poll_done_seen", 64'(rd_done_cnt != n0), 64'(1));
        n = 0;
        while (busy && n < BUDGET) begin @(negedge clk); n++; end
        check("poll_temp_q", 64'(temp_q), 64'(val));
        check("poll_temp_valid", 64'(temp_valid), 64'(1));
        check("poll_sb_drain", 64'(exp_q.size()), 64'(0));
    endtask

    // ---------------- vectors ----------------
    typedef struct {
        logic        wr;
        logic [1:0]  ptr;
        logic [7:0]  wdata;
        logic [15:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    vec_t vecs[8];

    initial begin
        logic        got, err;
        logic [15:0] rd;
        int          ack_c, n;

        vecs[0] = '{1'b1, 2'd1, 8'hA5, 16'h0000, 1'b0};
        vecs[1] = '{1'b0, 2'd1, 8'h00, 16'hA500, 1'b0};
        vecs[2] = '{1'b0, 2'd3, 8'h11, 16'h9821, 1'b0};
        vecs[3] = '{1'b1, 2'd0, 8'h77, 16'h0000, 1'b1};
        vecs[4] = '{1'b1, 2'd3, 8'h66, 16'h0000, 1'b1};
        vecs[5] = '{1'b1, 2'd2, 8'h3C, 16'h0000, 1'b0};
        vecs[6] = '{1'b0, 2'd2, 8'h00, 16'h3C00, 1'b0};
        vecs[7] = '{1'b0, 2'd0, 8'h00, 16'h1234, 1'b0};

        reg8[0] = 8'h00; reg8[1] = 8'h00; reg8[2] = 8'h00; reg8[3] = 8'h00;
        temp_model = 16'h1234; def_model = 16'h9821; cur_ptr = 2'd0;
        mute_all = 1'b0; mute_rd = 1'b0;
        rst_n = 1'b0; en = 1'b0; host_req = 1'b0; host_wr = 1'b0;
        host_ptr = 2'd0; host_wdata = 8'h00;
`ifdef TEMP_ALERT_EN
        alert_hi = 16'h1000; alert_lo = 16'h0800;
`endif

        // reset state
        repeat (3) @(negedge clk);
        check("reset_outputs", 64'({host_ack, host_rdata, host_err, temp_q, temp_valid, busy,
                                    m_init, m_rd_wr, m_wr, m_addr, m_cmd, m_data}), 64'(0));
        rst_n = 1'b1;
        @(negedge clk);
        check("idle_after_reset", 64'({busy, m_init, m_addr}), 64'(0));

        // table of host accesses, poll timer off
        for (int i = 0; i < 8; i++) begin
            if (!vecs[i].wr) begin
                exp_q.push_back(mk_txn(1'b0, 1'b0, vecs[i].ptr, 8'h00));
                exp_q.push_back(mk_txn(1'b1, 1'b0, vecs[i].ptr, 8'h00));
            end else if (vecs[i].ptr == 2'd1 || vecs[i].ptr == 2'd2) begin
                exp_q.push_back(mk_txn(1'b0, 1'b1, vecs[i].ptr, vecs[i].wdata));
            end
            host_op(vecs[i].wr, vecs[i].ptr, vecs[i].wdata, got, rd, err, ack_c);
            check($sformatf("vec%0d_ack", i), 64'(got), 64'(1));
            check($sformatf("vec%0d_err", i), 64'(err), 64'(vecs[i].exp_err));
            if (!vecs[i].wr) check($sformatf("vec%0d_rdata", i), 64'(rd), 64'(vecs[i].exp_rdata));
            check($sformatf("vec%0d_sb_drain", i), 64'(exp_q.size()), 64'(0));
            @(negedge clk);
            check($sformatf("vec%0d_single_ack", i), 64'(host_ack), 64'(0));
        end

        // periodic poll
        do_poll(16'h1234);

        // timeout: master never answers the pointer write
        mute_all = 1'b1;
        exp_q.push_back(mk_txn(1'b0, 1'b0, 2'd0, 8'h00));
        host_op(1'b0, 2'd0, 8'h00, got, rd, err, ack_c);
        check("to_ack", 64'(got), 64'(1));
        check("to_err", 64'(err), 64'(1));
        check("to_latency", 64'(ack_c - init_cyc), 64'(TIMEOUT_CYC + 1));
        @(negedge clk);
        check("to_idle", 64'(busy), 64'(0));
        check("to_temp_kept", 64'(temp_q), 64'(16'h1234));
        mute_all = 1'b0;

        // asynchronous reset while waiting for read data
        mute_rd = 1'b1;
        exp_q.push_back(mk_txn(1'b0, 1'b0, 2'd3, 8'h00));
        exp_q.push_back(mk_txn(1'b1, 1'b0, 2'd3, 8'h00));
        n = rd_init_cnt;
        host_wr = 1'b0; host_ptr = 2'd3; host_req = 1'b1;
        @(negedge clk);
        host_req = 1'b0;
        ack_c = 0;
        while (rd_init_cnt == n && ack_c < BUDGET) begin @(negedge clk); ack_c++; end
        check("rst_reached_rd", 64'(rd_init_cnt != n), 64'(1));
        repeat (3) @(negedge clk);
        check("rst_busy_before", 64'({busy, m_rd_wr}), 64'(2'b11));
        #2 rst_n = 1'b0;
        #1;
        check("rst_async_outputs", 64'({host_ack, host_rdata, host_err, temp_q, temp_valid, busy,
                                        m_init, m_rd_wr, m_wr, m_addr, m_cmd, m_data}), 64'(0));
        check("rst_sb_drain", 64'(exp_q.size()), 64'(0));
        mute_rd = 1'b0;
        repeat (2) @(negedge clk);

        // host request in the cycle poll_pend rises: host first, poll right after
        rst_n = 1'b1; en = 1'b1;
        repeat (POLL_DIV) @(negedge clk);
        temp_model = 16'h0BEE;
        exp_q.push_back(mk_txn(1'b0, 1'b0, 2'd1, 8'h00));
        exp_q.push_back(mk_txn(1'b1, 1'b0, 2'd1, 8'h00));
        exp_q.push_back(mk_txn(1'b0, 1'b0, 2'd0, 8'h00));
        exp_q.push_back(mk_txn(1'b1, 1'b0, 2'd0, 8'h00));
        host_op(1'b0, 2'd1, 8'h00, got, rd, err, ack_c);
        check("prio_ack", 64'(got), 64'(1));
        check("prio_rdata", 64'(rd), 64'(16'hA500));
        check("prio_no_temp_yet", 64'(temp_valid), 64'(0));
        repeat (2) @(negedge clk);
        check("prio_poll_launch", 64'({m_init, m_rd_wr, m_cmd}), 64'({1'b1, 1'b0, 8'h00}));
        n = 0;
        while (temp_q != 16'h0BEE && n < BUDGET) begin @(negedge clk); n++; end
        en = 1'b0;
        n = 0;
        while (busy && n < BUDGET) begin @(negedge clk); n++; end
        check("prio_temp_q", 64'(temp_q), 64'(16'h0BEE));
        check("prio_temp_valid", 64'(temp_valid), 64'(1));
        check("prio_sb_drain", 64'(exp_q.size()), 64'(0));

        // successive polls
        do_poll(16'h1234);
`ifdef TEMP_ALERT_EN
        check("alert_hi_cross", 64'(alert), 64'(1));
`endif
        do_poll(16'h0900);
`ifdef TEMP_ALERT_EN
        check("alert_hyst_hold", 64'(alert), 64'(1));
`endif
        do_poll(16'h0700);
`ifdef TEMP_ALERT_EN
        check("alert_lo_clear", 64'(alert), 64'(0));
`endif

        repeat (5) @(negedge clk);
        check("final_sb_empty", 64'(exp_q.size()), 64'(0));
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
